dut: RTL and testbench



---
 rtl/dut_pkg.sv | 21 ++
 rtl/dut_nand_cell.sv | 35 +++
 rtl/dut.sv | 62 ++++++
 tb/tb_dut.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dut_pkg.sv
// ============================================================================
// Module      : dut_pkg
// Description : Shared constants and types for the registered NAND datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dut_pkg;

  // Default operand/result width of the datapath.
  localparam int DUT_DEFAULT_WIDTH = 8;

  // Value every result bit takes while reset is asserted.
  localparam logic [DUT_DEFAULT_WIDTH-1:0] DUT_OUT_RESET = '0;

  // Word of the default datapath width.
  typedef logic [DUT_DEFAULT_WIDTH-1:0] dut_word_t;

endpackage : dut_pkg

`default_nettype wire

// File: rtl/dut_nand_cell.sv
// ============================================================================
// Module      : dut_nand_cell
// Description : One result bit: two-input NAND feeding an async-reset flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dut_nand_cell
  import dut_pkg::*;
#(
  parameter logic RESET_VAL = DUT_OUT_RESET[0]
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic q
);

  logic nand_val;

  assign nand_val = ~(a & b);

  // Capture the NAND of this bit pair on every edge; reset clears it at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else begin
      q <= nand_val;
    end
  end

endmodule : dut_nand_cell

`default_nettype wire

// File: rtl/dut.sv
// ============================================================================
// Module      : dut
// Description : Registered bitwise NAND of two WIDTH-bit operands, one clock
//               of latency. Defining DUT_PARITY_EN adds a registered parity
//               output (out_par) equal to the XOR of the loaded result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dut
  import dut_pkg::*;
#(
  parameter int WIDTH = DUT_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out
`ifdef DUT_PARITY_EN
  ,
  output logic             out_par
`endif
);

  // Each bit is an independent cell; there is no cross-bit interaction.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dut_nand_cell #(
        .RESET_VAL (1'b0)
      ) u_cell (
        .clk   (clk),
        .reset (reset),
        .a     (a[i]),
        .b     (b[i]),
        .q     (out[i])
      );
    end
  endgenerate

`ifdef DUT_PARITY_EN
  logic [WIDTH-1:0] nand_next;
  logic             par_next;

  // Parity is taken from the value the cells are about to load, so it lands
  // on the same edge as the result it describes.
  assign nand_next = ~(a & b);
  assign par_next  = ^nand_next;

  // Register parity alongside the result; reset clears it asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_par <= 1'b0;
    end else begin
      out_par <= par_next;
    end
  end
`endif

endmodule : dut

`default_nettype wire

// File: tb/tb_dut.sv
// ============================================================================
// Module      : tb_dut
// Description : Scoreboard bench for dut (WIDTH=8) plus a WIDTH=1 instance.
//               Parity checks are compiled in when DUT_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dut;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] out;
  logic [0:0] a1;
  logic [0:0] b1;
  logic [0:0] out1;
`ifdef DUT_PARITY_EN
  logic       out_par;
  logic       out_par1;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0] exp_out;
    logic       exp_par;
    int         id;
  } exp_t;

  exp_t sb_q[$];
  int   next_id = 0;

  dut #(.WIDTH(8)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .out     (out)
`ifdef DUT_PARITY_EN
    ,
    .out_par (out_par)
`endif
  );

  dut #(.WIDTH(1)) u_dut_w1 (
    .clk     (clk),
    .reset   (reset),
    .a       (a1),
    .b       (b1),
    .out     (out1)
`ifdef DUT_PARITY_EN
    ,
    .out_par (out_par1)
`endif
  );

  // Free-running clock, first rising edge at t=5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Per-bit reference NAND.
  function automatic logic [7:0] model_nand(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = !(x[i] && y[i]);
    return r;
  endfunction

  task automatic push_exp(input logic [7:0] e_out, input logic e_par);
    exp_t e;
    e.exp_out = e_out;
    e.exp_par = e_par;
    e.id      = next_id;
    next_id++;
    sb_q.push_back(e);
  endtask

  // Drive one operand pair away from the active edge and record its result.
  task automatic drive(input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] e_out, input logic e_par);
    @(negedge clk);
    a = va;
    b = vb;
    push_exp(e_out, e_par);
  endtask

  // Monitor: after every rising edge, compare the result for that edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("sb%0d_out", e.id), {56'd0, out}, {56'd0, e.exp_out});
`ifdef DUT_PARITY_EN
      check($sformatf("sb%0d_par", e.id), {63'd0, out_par}, {63'd0, e.exp_par});
`endif
    end
  end

  initial begin : stim
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rexp;
    int         wait_cycles;

    reset = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    a1    = 1'b0;
    b1    = 1'b0;

    // Reset takes effect before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_async_out", {56'd0, out}, 64'h00);
`ifdef DUT_PARITY_EN
    check("rst_async_par", {63'd0, out_par}, 64'h0);
`endif
    a = 8'hFF;
    b = 8'h00;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_hold_out", {56'd0, out}, 64'h00);
    end

    // Directed vectors.
    @(negedge clk);
    reset = 1'b0;
    a = 8'hF0;
    b = 8'hCC;
    push_exp(8'h3F, 1'b0);
    drive(8'hFF, 8'hFF, 8'h00, 1'b0);
    drive(8'h00, 8'h55, 8'hFF, 1'b0);

    // Output holds while an operand changes between edges.
    drive(8'hA5, 8'h0F, 8'hFA, 1'b0);
    @(negedge clk);
    a = 8'h00;
    #1;
    check("hold_between_edges", {56'd0, out}, 64'hFA);
    push_exp(8'hFF, 1'b0);

    // Mid-stream reset clears the held result asynchronously.
    drive(8'hA5, 8'h0F, 8'hFA, 1'b0);
    @(negedge clk);
    check("pre_reset_out", {56'd0, out}, 64'hFA);
    reset = 1'b1;
    #1;
    check("rst_mid_out", {56'd0, out}, 64'h00);
`ifdef DUT_PARITY_EN
    check("rst_mid_par", {63'd0, out_par}, 64'h0);
`endif
    @(posedge clk);
    #1;
    check("rst_mid_hold", {56'd0, out}, 64'h00);
    @(negedge clk);
    reset = 1'b0;
    a = 8'h81;
    b = 8'h81;
    push_exp(8'h7E, 1'b0);

    // Random operand pairs checked against the per-bit model.
    for (int n = 0; n < 1000; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rexp = model_nand(ra, rb);
      drive(ra, rb, rexp, ^rexp);
    end

    // Single-bit instance.
    @(negedge clk);
    a1 = 1'b1;
    b1 = 1'b1;
    @(posedge clk);
    #1;
    check("w1_a1_b1", {63'd0, out1}, 64'h0);
    @(negedge clk);
    b1 = 1'b0;
    @(posedge clk);
    #1;
    check("w1_a1_b0", {63'd0, out1}, 64'h1);

    // Let the scoreboard drain, bounded.
    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    check("sb_drain", 64'(sb_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_dut

`default_nettype wire
